pc_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the single-issue RISC-V datapath.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_incrementer.sv | 14 +
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The optional misaligned-redirect trap is enabled by defining MISALIGN_TRAP_EN.
package pc_seq_pkg;

  // Fetch sequencer state encoding
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  // A redirect target is misaligned when it is not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-PC adder: pc + INSTR_BYTES, wrapping modulo 2^XLEN.
module pc_incrementer
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o
);

  // Carry out of the top bit is dropped so 0xFFFF_FFFC rolls over to 0
  assign pc_next_o = pc_i + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer.
// Owns the PC, runs the imem request handshake and presents {pc, instr, valid} to decode.
// Define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR and pulse fetch_fault.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_BOOT  | one idle cycle after reset release
//  ST_FETCH | imem_req high at pc; waits for imem_ready, absorbs redirects
//  ST_HOLD  | instruction presented to decode; waits for !stall or redirect
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_valid,
  output logic            fetch_fault
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            imem_req_q;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_instr_q;
  logic            if_valid_q;
  logic            fetch_fault_q;
  logic            redirect_pend_q;
  logic [XLEN-1:0] redirect_tgt_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_raw;
  logic [XLEN-1:0] redir_pc_d;
  logic            trap_d;
  logic            redir_now;

  pc_incrementer #(.XLEN(XLEN)) u_inc (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4)
  );

  // A redirect in this cycle overrides any older pending one (latest wins)
  assign redir_raw = redirect_valid ? redirect_target : redirect_tgt_q;
  assign redir_now = redirect_valid | redirect_pend_q;

  // Resolve the PC a redirect actually loads, applying the alignment trap when enabled
  always_comb begin
    redir_pc_d = redir_raw;
    trap_d     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (is_misaligned(redir_raw[1:0])) begin
      redir_pc_d = TRAP_VECTOR;
      trap_d     = 1'b1;
    end
`endif
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      imem_req_q      <= 1'b0;
      if_pc_q         <= '0;
      if_instr_q      <= '0;
      if_valid_q      <= 1'b0;
      fetch_fault_q   <= 1'b0;
      redirect_pend_q <= 1'b0;
      redirect_tgt_q  <= '0;
    end else begin
      fetch_fault_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            if (redir_now) begin
              // Returned word belongs to the abandoned path; reissue at the new PC
              pc_q            <= redir_pc_d;
              fetch_fault_q   <= trap_d;
              redirect_pend_q <= 1'b0;
            end else begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              imem_req_q <= 1'b0;
              state_q    <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            // Request must stay stable at the old address until memory completes it
            redirect_pend_q <= 1'b1;
            redirect_tgt_q  <= redirect_target;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            if_valid_q    <= 1'b0;
            pc_q          <= redir_pc_d;
            fetch_fault_q <= trap_d;
            imem_req_q    <= 1'b1;
            state_q       <= ST_FETCH;
          end else if (!stall) begin
            if_valid_q <= 1'b0;
            pc_q       <= pc_plus4;
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a synchronous instruction-memory responder.
// Honours MISALIGN_TRAP_EN for the alignment-trap expectations.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fetch_fault;

  int total = 0;
  int bad = 0;
  int wait_cfg = 0;
  int mem_cnt = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_MIS_ADDR  = 32'h0000_0100;
  localparam logic [31:0] EXP_PEND_ADDR = 32'h0000_0100;
  localparam int          EXP_FAULT     = 1;
`else
  localparam logic [31:0] EXP_MIS_ADDR  = 32'h0000_0102;
  localparam logic [31:0] EXP_PEND_ADDR = 32'h0000_0083;
  localparam int          EXP_FAULT     = 0;
`endif

  pc_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_valid        (if_valid),
    .fetch_fault     (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // Synchronous memory: request seen on one cycle, ready returned after wait_cfg more
  always @(negedge clock) begin
    if (!reset_n) begin
      imem_ready = 1'b0;
      mem_cnt    = 0;
    end else if (imem_ready) begin
      imem_ready = 1'b0;
      mem_cnt    = 0;
    end else if (imem_req) begin
      if (mem_cnt >= wait_cfg + 1) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        mem_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (if_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
  endtask

  int  n;
  int  fault_cnt;
  logic saw_valid;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    reset_n = 1'b1;
    #1 chk("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);

    // Zero-wait sequential fetch: 0, 4, 8 every third cycle
    wait_valid("seq0", n);
    chk("seq0_lat", n, 32'd2);
    chk("seq0_pc", if_pc, 32'd0);
    chk("seq0_instr", if_instr, mem_word(32'd0));
    @(negedge clock);
    chk("seq1_addr", imem_addr, 32'd4);
    chk("seq1_nvalid", {31'd0, if_valid}, 32'd0);
    wait_valid("seq1", n);
    chk("seq1_period", n + 1, 32'd3);
    chk("seq1_pc", if_pc, 32'd4);
    @(negedge clock);
    chk("seq2_addr", imem_addr, 32'd8);
    wait_valid("seq2", n);
    chk("seq2_period", n + 1, 32'd3);
    chk("seq2_instr", if_instr, mem_word(32'd8));

    // Stall in HOLD for five cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'd8);
      chk("stall_instr", if_instr, mem_word(32'd8));
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clock);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'd12);
    wait_valid("pc12", n);
    chk("pc12_pc", if_pc, 32'd12);

    // Redirect beats stall in HOLD
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    @(negedge clock);
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("hredir_valid", {31'd0, if_valid}, 32'd0);
    chk("hredir_req", {31'd0, imem_req}, 32'd1);
    chk("hredir_addr", imem_addr, 32'h200);
    wait_valid("r200", n);
    chk("r200_pc", if_pc, 32'h200);

    // Redirect during a 3-wait fetch: returned word discarded
    wait_cfg = 3;
    @(negedge clock);
    chk("wf_addr", imem_addr, 32'h204);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0040;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("wf_hold_addr", imem_addr, 32'h204);
    chk("wf_hold_req", {31'd0, imem_req}, 32'd1);
    saw_valid = 1'b0;
    n = 0;
    while (imem_addr !== 32'h40 && n < 30) begin
      @(negedge clock);
      saw_valid = saw_valid | if_valid;
      n++;
    end
    chk("wf_no_valid", {31'd0, saw_valid}, 32'd0);
    chk("wf_new_addr", imem_addr, 32'h40);
    chk("wf_new_req", {31'd0, imem_req}, 32'd1);
    wait_cfg = 0;
    wait_valid("r40", n);
    chk("r40_pc", if_pc, 32'h40);
    chk("r40_instr", if_instr, mem_word(32'h40));

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wtop", n);
    chk("wtop_pc", if_pc, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    wait_valid("w0", n);

    // Misaligned redirect from HOLD
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0102;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, EXP_MIS_ADDR);
    chk("mis_fault", {31'd0, fetch_fault}, EXP_FAULT);
    @(negedge clock);
    chk("mis_fault_end", {31'd0, fetch_fault}, 32'd0);
    wait_valid("mis", n);

    // Misaligned redirect left pending in a waiting fetch
    wait_cfg = 3;
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0083;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("pend_fault_early", {31'd0, fetch_fault}, 32'd0);
    fault_cnt = 0;
    n = 0;
    while (imem_addr === EXP_MIS_ADDR + 32'd4 && n < 30) begin
      @(negedge clock);
      if (fetch_fault) fault_cnt++;
      n++;
    end
    chk("pend_addr", imem_addr, EXP_PEND_ADDR);
    chk("pend_fault_on_load", {31'd0, fetch_fault}, EXP_FAULT);
    repeat (3) begin
      @(negedge clock);
      if (fetch_fault) fault_cnt++;
    end
    chk("pend_fault_cnt", fault_cnt, EXP_FAULT);

    // Reset in the middle of a request
    reset_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cfg = 0;
    #1 chk("mrst_boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    chk("mrst_first_req", {31'd0, imem_req}, 32'd1);
    chk("mrst_first_addr", imem_addr, 32'd0);
    wait_valid("mrst", n);
    chk("mrst_pc", if_pc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
